// File: rtl/root_5_iter.sv
// root_5_iter: iterative floor fifth root of a 5*W-bit operand, one shared multiplier, MSB-first restoring search.
// Optional ROOT_5_ZERO_BYPASS_EN: an accepted zero operand resolves in one enabled cycle.
module root_5_iter #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clk_en,
   input  logic           x_vld,
   output logic           x_rdy,
   input  logic [5*W-1:0] x,
   output logic           res_vld,
   output logic [W-1:0]   res
);
   localparam int PW = 5 * W;
   localparam int KW = (W > 1) ? $clog2(W) : 1;
   typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;
   state_t         state_q, state_d;
   logic [1:0]     step_q, step_d;
   logic [KW-1:0]  k_q, k_d;
   logic [W-1:0]   r_q, r_d, res_q, res_d, t;
   logic [PW-1:0]  x_q, x_d, p_q, p_d, mul_a, mul;
   logic           res_vld_q, res_vld_d, fit;
   assign t     = r_q | (W'(1) << k_q);
   assign mul_a = (step_q == 2'd0) ? PW'(t) : p_q;
   assign mul   = mul_a * PW'(t);
   assign fit   = p_q <= x_q;
   assign x_rdy   = state_q == IDLE;
   assign res_vld = res_vld_q;
   assign res     = res_q;
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      k_d       = k_q;
      r_d       = r_q;
      x_d       = x_q;
      p_d       = p_q;
      res_d     = res_q;
      res_vld_d = 1'b0;
      case (state_q)
         IDLE: if (x_vld) begin
            x_d     = x;
            r_d     = '0;
            k_d     = KW'(W - 1);
            step_d  = 2'd0;
            state_d = MUL;
`ifdef ROOT_5_ZERO_BYPASS_EN
            // An all-ones product never fits under zero, so one CMP pass yields r=0.
            if (x == '0) begin
               p_d     = '1;
               k_d     = '0;
               state_d = CMP;
            end
`endif
         end
         MUL: begin
            p_d     = mul;
            step_d  = step_q + 2'd1;
            state_d = (step_q == 2'd3) ? CMP : MUL;
         end
         CMP: begin
            r_d = fit ? t : r_q;
            if (k_q == '0) begin
               res_d     = fit ? t : r_q;
               res_vld_d = 1'b1;
               state_d   = IDLE;
            end else begin
               k_d     = k_q - 1'b1;
               step_d  = 2'd0;
               state_d = MUL;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         step_q    <= '0;
         k_q       <= KW'(W - 1);
         r_q       <= '0;
         x_q       <= '0;
         p_q       <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
      end else if (clk_en) begin
         state_q   <= state_d;
         step_q    <= step_d;
         k_q       <= k_d;
         r_q       <= r_d;
         x_q       <= x_d;
         p_q       <= p_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
      end
   end
endmodule

// File: tb/tb_root_5_iter.sv
// tb_root_5_iter: directed vectors for root_5_iter with hand-computed roots and latencies.
module tb_root_5_iter;
   logic        clk = 0, rst = 1, clk_en = 1, x_vld = 0;
   logic [39:0] x = '0;
   logic        x_rdy, res_vld;
   logic [7:0]  res;
   int          checks = 0, errors = 0;
   root_5_iter #(.W(8)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .x_vld(x_vld), .x_rdy(x_rdy),
      .x(x), .res_vld(res_vld), .res(res)
   );
   always #5 clk = ~clk;
`ifdef ROOT_5_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 40;
`endif
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic accept(input logic [39:0] xv);
      clk_en = 1;
      x = xv;
      x_vld = 1;
      @(posedge clk);
      #1;
      x_vld = 0;
      x = ~xv;
   endtask
   task automatic wait_res(input string tag, input logic [7:0] er, input int el, input bit rnd);
      int n = 0;
      bit seen = 0, en;
      for (int i = 0; i < 600 && !seen; i++) begin
         en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         clk_en = en;
         @(posedge clk);
         #1;
         if (en) n++;
         if (res_vld) seen = 1;
      end
      check({tag, "_lat"}, n, el);
      check({tag, "_res"}, res, er);
      check({tag, "_rdy"}, x_rdy, 1);
      clk_en = 0;
      @(posedge clk);
      #1;
      check({tag, "_vld_hold"}, res_vld, 1);
      clk_en = 1;
      @(posedge clk);
      #1;
      check({tag, "_vld_drop"}, res_vld, 0);
   endtask
   task automatic op(input string tag, input logic [39:0] xv, input logic [7:0] er, input int el, input bit rnd);
      accept(xv);
      wait_res(tag, er, el, rnd);
   endtask
   initial begin
      int stray;
      #12;
      check("rst_rdy", x_rdy, 1);
      check("rst_vld", res_vld, 0);
      check("rst_res", res, 0);
      rst = 0;
      @(posedge clk);
      #1;
      op("x243", 40'd243, 8'd3, 40, 0);
      op("x242", 40'd242, 8'd2, 40, 0);
      op("x1", 40'd1, 8'd1, 40, 0);
      op("xmax", 40'hFF_FFFF_FFFF, 8'd255, 40, 0);
      op("x32p5", 40'd33554432, 8'd32, 40, 0);
      op("x0", 40'd0, 8'd0, ZLAT, 0);
      op("x7776", 40'd7776, 8'd6, 40, 1);
      // operand held valid and changing while busy; then back-to-back accept
      clk_en = 1;
      x = 40'd243;
      x_vld = 1;
      @(posedge clk);
      #1;
      check("busy_rdy", x_rdy, 0);
      for (int i = 0; i < 39; i++) begin
         x = 40'd1024 + 40'(i);
         @(posedge clk);
         #1;
      end
      x = 40'd3125;
      @(posedge clk);
      #1;
      check("busy_vld", res_vld, 1);
      check("busy_res", res, 3);
      @(posedge clk);
      #1;
      x_vld = 0;
      x = 40'd1;
      check("b2b_vld_drop", res_vld, 0);
      check("b2b_rdy", x_rdy, 0);
      wait_res("b2b", 8'd5, 40, 0);
      // reset in the middle of an operation
      accept(40'd243);
      for (int i = 0; i < 19; i++) begin
         @(posedge clk);
         #1;
      end
      check("mid_busy", x_rdy, 0);
      rst = 1;
      #1;
      check("mid_rst_rdy", x_rdy, 1);
      check("mid_rst_vld", res_vld, 0);
      check("mid_rst_res", res, 0);
      @(posedge clk);
      #1;
      rst = 0;
      stray = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (res_vld) stray++;
      end
      check("no_stray_vld", stray, 0);
      op("x3125", 40'd3125, 8'd5, 40, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
